pushbutton_op_select: RTL and testbench
=======================================

// Module: pushbutton_op_select
// PURPOSE
//  Conditions the two raw board pushbuttons into clean, sticky operation-select levels for the
//  downstream AND/ADD datapath (its left_pushbutton / right_pushbutton inputs).
//  Each button is synchronised and debounced, and its press is edge-detected. The block holds the
//  last-selected mode. Exactly one select output is high after the first press.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synced cycles before the debounced level changes (>=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)+1  debounce counter width; derived, do not override
// PORTS
//  clk               input   1  system clock; all state updates on posedge
//  reset             input   1  asynchronous, active-high reset
//  left_btn_raw      input   1  raw left pushbutton; asynchronous, bouncy
//  right_btn_raw     input   1  raw right pushbutton; asynchronous, bouncy
//  left_pushbutton   output  1  registered; high while mode==AND (selects A&B downstream)
//  right_pushbutton  output  1  registered; high while mode==ADD (selects A+B downstream)
//  mode              output  2  registered current mode: 00 IDLE, 01 AND, 10 ADD (11 never driven)
//  press_pulse       output  1  registered; 1-cycle pulse on the cycle the mode register is written
// BEHAVIOUR
//  Reset (async assert, sync-released by the system):
//  - All outputs are 0: mode=IDLE. Synchronisers, debounced levels and counters are cleared.
//  Synchroniser:
//  - Each raw input passes through two flops. Synced value lags raw by 2 edges.
//  Debounce (per button):
//  - When synced != stable, cnt increments. When synced == stable, cnt clears to 0.
//  - When synced != stable and cnt == DEBOUNCE_CYCLES-1, stable <= synced and cnt <= 0.
//  - Any disagreement shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
//  - A rise is stable 0->1. Release (1->0) is debounced identically but produces no rise.
//  Mode state machine (IDLE, AND, ADD):
//  - left rise only -> AND. right rise only -> ADD.
//  - Both rises in the same cycle -> AND (left has priority).
//  - No rise -> hold. A rise for the already-current mode rewrites the same value.
//  - Releases never change mode. Mode is sticky until the next press.
//  - IDLE is reachable only via reset.
//  Outputs:
//  - All outputs are registered alongside mode: left_pushbutton = (mode==AND),
//    right_pushbutton = (mode==ADD).
//  - press_pulse = 1 for exactly one cycle on every mode-register write, including a same-value write.
//  - left_pushbutton and right_pushbutton are never both 1.
//  Latency:
//  - Raw edge held steady to select output change: DEBOUNCE_CYCLES + 3 clk edges
//    (2 sync + DEBOUNCE_CYCLES debounce + 1 mode register).
//  Reset mid-debounce:
//  - Partial counts are discarded. After release, a held button needs the full latency again.
// STRUCTURE
//  Shared package:
//  - MODE_IDLE=2'b00, MODE_AND=2'b01, MODE_ADD=2'b10.
//  - Default DEBOUNCE_CYCLES; hardware builds override it to 1_000_000 at 100 MHz.
//  Sub-module button_debounce (params DEBOUNCE_CYCLES, CNT_W):
//  - Ports: clk, reset, raw, stable, rise.
//  - Contains the 2-flop sync, counter and edge detect. Instantiated twice.
//  Top-level holds only the mode register and output decode.
// TESTING  (DEBOUNCE_CYCLES=4, latency 7 edges)
//  1. Reset, then left_btn_raw=1 held:
//     - 7th edge: mode=01, left_pushbutton=1, right_pushbutton=0, press_pulse=1 for 1 cycle.
//  2. From AND, right_btn_raw pulsed high for 3 cycles then low:
//     - Glitch: mode stays 01, no press_pulse.
//     - Then held 10 cycles: mode=10 at 7th edge, left=0, right=1.
//  3. Bounce: right_btn_raw toggles 1,0,1,0,1 each cycle, then steady 1:
//     - Exactly one press_pulse, 7 edges after the last toggle.
//  4. Both raw inputs rise on the same edge from ADD:
//     - mode=01 after 7 edges, left_pushbutton=1, one press_pulse.
//  5. Release left after AND selected:
//     - mode stays 01 indefinitely, no press_pulse.
//     - Re-press left: press_pulse again, mode stays 01.
//  6. Assert reset 2 cycles into a left debounce:
//     - All outputs 0 immediately (async).
//     - After release with left still held, mode=01 exactly 7 edges later.

Source files
------------

// File: rtl/pushbutton_op_select_pkg.sv
// Shared definitions for the pushbutton operation-select block.
package pushbutton_op_select_pkg;

    // Operation-select mode, encoded as seen on the mode output port.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_AND  = 2'b01,
        MODE_ADD  = 2'b10
    } mode_t;

    // Simulation-friendly default; hardware builds override to 1_000_000 (10 ms at 100 MHz).
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/pushbutton_op_select_button_debounce.sv
// Per-button conditioning: 2-flop synchroniser, stability counter and rise detect.
module button_debounce
    import pushbutton_op_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             synced;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous raw button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            synced    <= 1'b0;
        end else begin
            sync_meta <= raw;
            synced    <= sync_meta;
        end
    end

    // Accept a new level only after it has disagreed with the current one for
    // DEBOUNCE_CYCLES consecutive cycles; flag a rise in the same update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= synced;
                cnt    <= '0;
                rise   <= synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pushbutton_op_select.sv
// Turns two bouncy board pushbuttons into sticky AND/ADD select levels.
module pushbutton_op_select
    import pushbutton_op_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_btn_raw,
    input  logic       right_btn_raw,
    output logic       left_pushbutton,
    output logic       right_pushbutton,
    output logic [1:0] mode,
    output logic       press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic  left_stable;
    logic  left_rise;
    logic  right_stable;
    logic  right_rise;

    mode_t mode_q;
    mode_t mode_next;
    logic  write_next;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_left_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (left_btn_raw),
        .stable (left_stable),
        .rise   (left_rise)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_right_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (right_btn_raw),
        .stable (right_stable),
        .rise   (right_rise)
    );

    // Mode register plus the select/pulse outputs registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q           <= MODE_IDLE;
            left_pushbutton  <= 1'b0;
            right_pushbutton <= 1'b0;
            press_pulse      <= 1'b0;
        end else begin
            mode_q           <= mode_next;
            left_pushbutton  <= (mode_next == MODE_AND);
            right_pushbutton <= (mode_next == MODE_ADD);
            press_pulse      <= write_next;
        end
    end

    // Any rise writes the mode (left wins a tie); releases leave it alone.
    always_comb begin
        mode_next  = mode_q;
        write_next = 1'b0;
        if (left_rise) begin
            mode_next  = MODE_AND;
            write_next = 1'b1;
        end else if (right_rise) begin
            mode_next  = MODE_ADD;
            write_next = 1'b1;
        end
    end

    assign mode = mode_q;

    // A rise is only ever reported together with the debounced level being high.
    a_left_rise_stable : assert property (@(posedge clk) disable iff (reset) left_rise |-> left_stable);
    a_right_rise_stable : assert property (@(posedge clk) disable iff (reset) right_rise |-> right_stable);

endmodule

// File: tb/tb_pushbutton_op_select.sv
// Bench for pushbutton_op_select: directed scenarios with literal expectations,
// then randomized button activity, all checked every cycle against a window model.
module tb_pushbutton_op_select;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       left_btn_raw = 1'b0;
    logic       right_btn_raw = 1'b0;
    logic       left_pushbutton;
    logic       right_pushbutton;
    logic [1:0] mode;
    logic       press_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    pushbutton_op_select #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .left_btn_raw     (left_btn_raw),
        .right_btn_raw    (right_btn_raw),
        .left_pushbutton  (left_pushbutton),
        .right_pushbutton (right_pushbutton),
        .mode             (mode),
        .press_pulse      (press_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A button's debounced level flips once the last N synchronised samples all
    // disagree with it; synchronised sample at edge k is the raw value seen at edge k-2.
    // A flip to 1 writes the mode one edge later.
    bit       raw_d1 [2];
    bit       raw_d2 [2];
    bit [N-1:0] hist [2];
    int unsigned fill [2];
    bit       stable_m [2];
    bit       rise_p [2];
    int       mode_m = 0;
    bit       pulse_m = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                raw_d1[b] = 0; raw_d2[b] = 0; hist[b] = '0; fill[b] = 0;
                stable_m[b] = 0; rise_p[b] = 0;
            end
            mode_m = 0;
            pulse_m = 0;
        end else begin
            bit rawnow [2];
            bit synced;
            rawnow[0] = left_btn_raw;
            rawnow[1] = right_btn_raw;
            pulse_m = rise_p[0] | rise_p[1];
            if (rise_p[0]) mode_m = 1;
            else if (rise_p[1]) mode_m = 2;
            for (int b = 0; b < 2; b++) begin
                synced = raw_d2[b];
                raw_d2[b] = raw_d1[b];
                raw_d1[b] = rawnow[b];
                hist[b] = {hist[b][N-2:0], synced};
                if (fill[b] < N) fill[b]++;
                rise_p[b] = 0;
                if (fill[b] == N && hist[b] == {N{~stable_m[b]}}) begin
                    stable_m[b] = ~stable_m[b];
                    rise_p[b] = stable_m[b];
                    fill[b] = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("mode", int'(mode), mode_m);
        chk("left_pushbutton", int'(left_pushbutton), int'(mode_m == 1));
        chk("right_pushbutton", int'(right_pushbutton), int'(mode_m == 2));
        chk("press_pulse", int'(press_pulse), int'(pulse_m));
        chk("selects_exclusive", int'(left_pushbutton & right_pushbutton), 0);
    end

    // ---------------- stimulus ----------------
    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            nxt();
            cnt += int'(press_pulse);
        end
    endtask

    task automatic no_pulse_for(input string name, input int n);
        int c;
        count_pulses(n, c);
        chk(name, c, 0);
    endtask

    initial begin
        int c;
        int hold_l = 0;
        int hold_r = 0;
        int rst_left = 0;

        // 1: reset, then left held
        nxt(3);
        chk("reset_mode", int'(mode), 0);
        chk("reset_pulse", int'(press_pulse), 0);
        reset = 1'b0;
        left_btn_raw = 1'b1;
        no_pulse_for("s1_no_early_pulse", 6);
        chk("s1_mode_edge6", int'(mode), 0);
        nxt();
        chk("s1_mode_edge7", int'(mode), 1);
        chk("s1_left", int'(left_pushbutton), 1);
        chk("s1_right", int'(right_pushbutton), 0);
        chk("s1_pulse", int'(press_pulse), 1);
        nxt();
        chk("s1_pulse_one_cycle", int'(press_pulse), 0);

        // 2: short right glitch, then a real right press
        right_btn_raw = 1'b1;
        nxt(3);
        right_btn_raw = 1'b0;
        no_pulse_for("s2_glitch_pulse", 12);
        chk("s2_glitch_mode", int'(mode), 1);
        right_btn_raw = 1'b1;
        nxt(6);
        chk("s2_mode_edge6", int'(mode), 1);
        nxt();
        chk("s2_mode_edge7", int'(mode), 2);
        chk("s2_left", int'(left_pushbutton), 0);
        chk("s2_right", int'(right_pushbutton), 1);
        chk("s2_pulse", int'(press_pulse), 1);
        nxt(3);

        // 3: release, then a bouncy right press
        right_btn_raw = 1'b0;
        left_btn_raw = 1'b0;
        no_pulse_for("s3_release_pulse", 12);
        chk("s3_release_mode", int'(mode), 2);
        right_btn_raw = 1'b1; nxt();
        right_btn_raw = 1'b0; nxt();
        right_btn_raw = 1'b1; nxt();
        right_btn_raw = 1'b0; nxt();
        right_btn_raw = 1'b1;
        no_pulse_for("s3_bounce_early", 6);
        nxt();
        chk("s3_pulse_edge7", int'(press_pulse), 1);
        chk("s3_mode", int'(mode), 2);
        no_pulse_for("s3_single_pulse", 6);

        // 4: both rise together from ADD
        right_btn_raw = 1'b0;
        no_pulse_for("s4_release_pulse", 12);
        left_btn_raw = 1'b1;
        right_btn_raw = 1'b1;
        nxt(6);
        chk("s4_mode_edge6", int'(mode), 2);
        nxt();
        chk("s4_mode_edge7", int'(mode), 1);
        chk("s4_left", int'(left_pushbutton), 1);
        chk("s4_right", int'(right_pushbutton), 0);
        chk("s4_pulse", int'(press_pulse), 1);
        no_pulse_for("s4_single_pulse", 6);

        // 5: release keeps AND; re-press rewrites AND
        left_btn_raw = 1'b0;
        right_btn_raw = 1'b0;
        no_pulse_for("s5_release_pulse", 20);
        chk("s5_mode_sticky", int'(mode), 1);
        left_btn_raw = 1'b1;
        nxt(7);
        chk("s5_repress_pulse", int'(press_pulse), 1);
        chk("s5_repress_mode", int'(mode), 1);

        // 6: reset two cycles into a left debounce
        left_btn_raw = 1'b0;
        nxt(10);
        left_btn_raw = 1'b1;
        nxt(2);
        reset = 1'b1;
        #1;
        chk("s6_async_mode", int'(mode), 0);
        chk("s6_async_left", int'(left_pushbutton), 0);
        chk("s6_async_right", int'(right_pushbutton), 0);
        chk("s6_async_pulse", int'(press_pulse), 0);
        nxt(2);
        reset = 1'b0;
        nxt(6);
        chk("s6_mode_edge6", int'(mode), 0);
        nxt();
        chk("s6_mode_edge7", int'(mode), 1);
        chk("s6_pulse", int'(press_pulse), 1);

        // Randomized activity: mixed glitches and long holds, occasional reset
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(399, 0) == 0) begin
                reset = 1'b1;
                rst_left = int'($urandom_range(3, 1));
            end
            if (hold_l == 0) begin
                left_btn_raw = 1'($urandom_range(1, 0));
                hold_l = int'($urandom_range(10, 1));
            end else hold_l--;
            if (hold_r == 0) begin
                right_btn_raw = 1'($urandom_range(1, 0));
                hold_r = int'($urandom_range(10, 1));
            end else hold_r--;
        end
        reset = 1'b0;
        nxt(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
